// File: rtl/adc_scheduler.sv
// adc_scheduler: round-robin conversion scheduler for a 4-channel ADC front end.
// The scheduler grants one pending channel and selects it on the analog mux. It
// waits for the mux to settle and then starts a conversion. When the result
// arrives, or the wait times out, it acks the channel.
//
// Ports:
//   clk            clock, rising edge
//   rstn           synchronous active-low reset
//   req_i[3:0]     per-channel request levels, held until matching ack
//   ack_o[3:0]     one-hot completion pulse
//   result_o[7:0]  conversion result, non-zero only in the ack cycle
//   err_o          timeout flag, only in the ack cycle
//   mux_sel_o[1:0] analog mux channel select
//   adc_restart_o  one-cycle conversion start pulse
//   adc_busy_i     ADC controller busy
//   adc_valid_i    ADC controller result valid
//   adc_count_i    ADC controller result
//   sched_busy_o   high whenever the scheduler is not idle
//
// Optional feature: define ADC_SCHEDULER_OVERSAMPLE_EN to run four conversions
// per grant. The reported result is then the average of the four.
module adc_scheduler #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req_i,
    output logic [3:0] ack_o,
    output logic [7:0] result_o,
    output logic       err_o,
    output logic [1:0] mux_sel_o,
    output logic       adc_restart_o,
    input  logic       adc_busy_i,
    input  logic       adc_valid_i,
    input  logic [7:0] adc_count_i,
    output logic       sched_busy_o
);

    localparam logic [9:0] SettleLast  = 10'(SETTLE_CYCLES - 1);
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StStart,
        StWait,
        StCapture,
        StAck
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  mux_q, mux_d;      // doubles as the granted channel
    logic [9:0]  cnt_q, cnt_d;      // settle counter in SELECT, timeout counter in WAIT
    logic [7:0]  count_q, count_d;
    logic [7:0]  result_q, result_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;    // req of the granted channel fell during the operation
    logic        mask_q, mask_d;    // block regrant of the just-acked channel for one cycle
    logic        restart_c;

`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
    logic [1:0]  pass_q, pass_d;
    logic [9:0]  acc_q, acc_d;
    logic [9:0]  acc_sum;
    assign acc_sum = acc_q + {2'b00, count_q};
`endif

    // Round-robin arbitration: rotate the eligible vector so rr_q sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [3:0] mask_vec;
    logic [3:0] elig;
    logic [7:0] elig2;
    logic [3:0] rot;
    logic       grant_vld;
    logic [1:0] grant_off;
    logic [1:0] grant_ch;

    always_comb begin
        mask_vec  = mask_q ? (4'b0001 << mux_q) : 4'b0000;
        elig      = req_i & ~mask_vec;
        elig2     = {elig, elig};
        rot       = elig2[rr_q +: 4];
        grant_vld = |rot;
        grant_off = 2'd0;
        if (rot[0]) begin
            grant_off = 2'd0;
        end else if (rot[1]) begin
            grant_off = 2'd1;
        end else if (rot[2]) begin
            grant_off = 2'd2;
        end else if (rot[3]) begin
            grant_off = 2'd3;
        end
        grant_ch = rr_q + grant_off;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        mux_d     = mux_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        result_d  = result_q;
        err_d     = err_q;
        drop_d    = drop_q;
        mask_d    = 1'b0;
        restart_c = 1'b0;
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
        pass_d    = pass_q;
        acc_d     = acc_q;
`endif

        if (state_q != StIdle && !req_i[mux_q]) begin
            drop_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                cnt_d = 10'd0;
                if (grant_vld) begin
                    mux_d    = grant_ch;
                    rr_d     = grant_ch + 2'd1;
                    drop_d   = 1'b0;
                    err_d    = 1'b0;
                    result_d = 8'h00;
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
                    pass_d   = 2'd0;
                    acc_d    = 10'd0;
`endif
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = 10'd0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StStart: begin
                if (!adc_busy_i) begin
                    restart_c = 1'b1;
                    cnt_d     = 10'd0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (adc_valid_i) begin
                    count_d = adc_count_i;
                    state_d = StCapture;
                end else if (cnt_q == TimeoutLast) begin
                    err_d    = 1'b1;
                    result_d = 8'h00;
                    state_d  = StAck;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StCapture: begin
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
                if (pass_q == 2'd3) begin
                    result_d = acc_sum[9:2];
                    state_d  = StAck;
                end else begin
                    acc_d   = acc_sum;
                    pass_d  = pass_q + 2'd1;
                    state_d = StStart;
                end
`else
                result_d = count_q;
                state_d  = StAck;
`endif
            end
            StAck: begin
                mask_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            rr_q     <= 2'd0;
            mux_q    <= 2'd0;
            cnt_q    <= 10'd0;
            count_q  <= 8'h00;
            result_q <= 8'h00;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            mask_q   <= 1'b0;
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
            pass_q   <= 2'd0;
            acc_q    <= 10'd0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            mux_q    <= mux_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            result_q <= result_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            mask_q   <= mask_d;
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
            pass_q   <= pass_d;
            acc_q    <= acc_d;
`endif
        end
    end

    // Outputs are forced low while rstn is asserted, so nothing leaks out of an
    // aborted operation during the reset cycle itself.
    logic ack_fire;
    assign ack_fire      = rstn && (state_q == StAck) && !drop_q && req_i[mux_q];
    assign ack_o         = ack_fire ? (4'b0001 << mux_q) : 4'b0000;
    assign result_o      = ack_fire ? result_q : 8'h00;
    assign err_o         = ack_fire & err_q;
    assign mux_sel_o     = rstn ? mux_q : 2'd0;
    assign adc_restart_o = rstn & restart_c;
    assign sched_busy_o  = rstn && (state_q != StIdle);

endmodule

// File: tb/tb_adc_scheduler.sv
// Self-checking bench for adc_scheduler. The bench plays the role of the
// requesters and of the ADC controller. A transaction-level reference model
// works out the expected outputs for every cycle. It does this from grant,
// restart and ack times computed with plain arithmetic.
module tb_adc_scheduler;

    localparam int S = 4;
    localparam int T = 300;
`ifdef ADC_SCHEDULER_OVERSAMPLE_EN
    localparam int NPASS = 4;
`else
    localparam int NPASS = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       busy = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] cnt = 8'h00;
    logic [3:0] ack_o;
    logic [7:0] result_o;
    logic       err_o;
    logic [1:0] mux_sel_o;
    logic       adc_restart_o;
    logic       sched_busy_o;

    always #5 clk = ~clk;

    adc_scheduler #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_i        (req),
        .ack_o        (ack_o),
        .result_o     (result_o),
        .err_o        (err_o),
        .mux_sel_o    (mux_sel_o),
        .adc_restart_o(adc_restart_o),
        .adc_busy_i   (busy),
        .adc_valid_i  (valid),
        .adc_count_i  (cnt),
        .sched_busy_o (sched_busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state
    bit         m_act = 0;
    int         m_ch = 0, m_g = 0, m_r = -1, m_start = 0, m_v = 0, m_pass = 0, m_sum = 0;
    int         m_rr = 0, m_mask = -1, m_wait_entry = 0, acks_model = 0;
    bit         m_drop = 0;
    logic [1:0] m_mux = 2'd0;
    logic [7:0] m_cnt = 8'h00;
    logic [3:0] pend = 4'b0000;
    int         last_rise[4];

    // Stimulus knobs
    logic [3:0] k_allow = 4'b0000;
    int k_req = 0, k_busy = 0, k_hold = 0, k_noise = 0, k_to = 0, k_drop = 0, k_keep = 0;
    int k_vfix = 0, k_vmax = 10, k_cnt_mode = 0, k_force_to = 0;
    logic [7:0] k_cnt = 8'h00;
    bit k_rst = 0;

    // Observations of the DUT
    int dut_acks = 0, dut_ack_cyc = 0, dut_restarts = 0, dut_restart_cyc = 0;
    logic [7:0] dut_last_res = 8'h00;
    logic       dut_last_err = 1'b0;
    int ack_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic [3:0] e_ack;
        logic [7:0] e_res;
        logic       e_err, e_rst, e_busy;
        logic [1:0] e_mux;
        bit         grant, ack_now;
        int         gch, cur_mask, ch;

        // Drive inputs for this cycle
        rstn = ~k_rst;
        k_rst = 0;
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && k_allow[i] && !(m_act && i == m_ch) &&
                $urandom_range(99, 0) < k_req) begin
                pend[i] = 1'b1;
                last_rise[i] = cyc;
            end
        end
        if (m_act && pend[m_ch] && $urandom_range(99, 0) < k_drop) pend[m_ch] = 1'b0;
        req = pend;

        // A finished capture that still has passes left starts a new START phase
        if (m_act && m_r >= 0 && m_v > 0 && cyc == m_r + m_v + 2 && m_pass < NPASS - 1) begin
            m_pass++;
            m_r = -1;
            m_start = cyc;
        end

        busy = ($urandom_range(99, 0) < k_busy);
        if (m_act && m_r < 0 && cyc >= m_start && cyc < m_start + k_hold) busy = 1'b1;
        valid = ($urandom_range(99, 0) < k_noise);
        cnt = 8'($urandom);

        e_ack = 4'b0000; e_res = 8'h00; e_err = 1'b0; e_rst = 1'b0;
        e_mux = m_mux; e_busy = m_act;
        grant = 0; gch = 0; ack_now = 0;
        cur_mask = m_mask;
        m_mask = -1;

        if (!rstn) begin
            e_mux = 2'd0;
            e_busy = 1'b0;
        end else if (!m_act) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_rr + i) % 4;
                if (!grant && req[c] && c != cur_mask) begin
                    grant = 1;
                    gch = c;
                end
            end
            if (grant) begin
                m_act = 1; m_ch = gch; m_g = cyc; m_rr = (gch + 1) % 4;
                m_start = cyc + S + 1; m_r = -1; m_pass = 0; m_sum = 0; m_drop = 0;
            end
        end else begin
            if (!req[m_ch]) m_drop = 1;
            if (m_r < 0) begin
                if (cyc >= m_start && !busy) begin
                    e_rst = 1'b1;
                    m_r = cyc;
                    m_wait_entry = cyc + 1;
                    if (k_force_to > 0) begin
                        m_v = 0;
                        k_force_to--;
                    end else if ($urandom_range(99, 0) < k_to) begin
                        m_v = 0;
                    end else begin
                        m_v = (k_vfix > 0) ? k_vfix : int'($urandom_range(k_vmax, 1));
                    end
                    case (k_cnt_mode)
                        1: m_cnt = k_cnt;
                        2: m_cnt = 8'(8'h10 + m_ch);
                        3: m_cnt = 8'(8'h40 + m_pass);
                        default: m_cnt = 8'($urandom);
                    endcase
                end
            end else if (m_v == 0) begin
                if (cyc <= m_r + T) valid = 1'b0;
                else begin
                    ack_now = 1; e_err = 1'b1; e_res = 8'h00;
                end
            end else if (cyc < m_r + m_v) begin
                valid = 1'b0;
            end else if (cyc == m_r + m_v) begin
                valid = 1'b1;
                cnt = m_cnt;
            end else if (cyc == m_r + m_v + 1) begin
                m_sum += m_cnt;
            end else begin
                ack_now = 1;
                e_err = 1'b0;
                e_res = (NPASS == 1) ? m_cnt : 8'(m_sum >> 2);
            end
            if (ack_now) begin
                if (!m_drop && req[m_ch]) begin
                    e_ack = 4'b0001 << m_ch;
                    acks_model++;
                    if ($urandom_range(99, 0) >= k_keep) pend[m_ch] = 1'b0;
                end else begin
                    e_res = 8'h00;
                    e_err = 1'b0;
                end
                m_act = 0;
                m_mask = m_ch;
            end
        end

        @(negedge clk);
        check("ack", ack_o, e_ack);
        check("result", result_o, e_res);
        check("err", err_o, e_err);
        check("mux_sel", mux_sel_o, e_mux);
        check("adc_restart", adc_restart_o, e_rst);
        check("sched_busy", sched_busy_o, e_busy);
        if (ack_o != 4'b0000) begin
            ch = 0;
            for (int i = 0; i < 4; i++) if (ack_o[i]) ch = i;
            dut_acks++;
            dut_ack_cyc = cyc;
            dut_last_res = result_o;
            dut_last_err = err_o;
            ack_log.push_back(ch);
        end
        if (adc_restart_o) begin
            dut_restarts++;
            dut_restart_cyc = cyc;
        end

        @(posedge clk);
        #1;
        if (grant) m_mux = 2'(gch);
        if (!rstn) begin
            m_act = 0; m_rr = 0; m_mux = 2'd0; m_mask = -1;
        end
        cyc++;
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (acks_model < target && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(acks_model >= target), 32'd1);
    endtask

    task automatic drain();
        int n;
        k_allow = 4'b0000; k_keep = 0; k_drop = 0; k_hold = 0; k_force_to = 0;
        n = 0;
        while ((pend != 4'b0000 || m_act) && n < 3000) begin
            step();
            n++;
        end
        check("drain_done", 32'(pend == 4'b0000 && !m_act), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        int base, r0, base_dut;
        for (int i = 0; i < 4; i++) last_rise[i] = 0;
        @(posedge clk);
        #1;

        // Reset: all outputs quiet
        repeat (3) begin
            k_rst = 1;
            step();
        end
        repeat (2) step();

        // Single request, fixed ADC latency, latency check
        k_allow = 4'b0001; k_req = 100; k_vfix = 20; k_cnt_mode = 1; k_cnt = 8'hA5;
        run_until(1, 400, "p1_done");
        check("p1_latency", 32'(dut_ack_cyc - last_rise[0]), 32'(S + 1 + NPASS * (20 + 2)));
        check("p1_result", dut_last_res, 8'hA5);
        check("p1_restarts", dut_restarts, NPASS);
        drain();

        // Oversample pattern (single pass reports the first count)
        k_allow = 4'b1000; k_req = 100; k_vfix = 6; k_cnt_mode = 3;
        base = acks_model;
        run_until(base + 1, 400, "p1b_done");
        check("p1b_result", dut_last_res, (NPASS == 4) ? 8'h41 : 8'h40);
        drain();

        // All channels requesting: round-robin order from reset
        k_rst = 1;
        step();
        ack_log.delete();
        k_allow = 4'b1111; k_req = 100; k_keep = 100; k_cnt_mode = 2; k_vfix = 5;
        base = acks_model;
        run_until(base + 5, 1000, "p2_done");
        check("p2_nacks", ack_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ack_log.size()) check("p2_order", ack_log[i], i % 4);
        end
        drain();

        // Timeout, then a normal conversion on the same channel
        k_allow = 4'b0100; k_req = 100; k_force_to = 1; k_vfix = 3; k_cnt_mode = 0;
        base = acks_model;
        run_until(base + 1, 800, "p3_to_done");
        check("p3_to_latency", 32'(dut_ack_cyc - m_wait_entry), T);
        check("p3_to_err", dut_last_err, 1'b1);
        check("p3_to_result", dut_last_res, 8'h00);
        run_until(base + 2, 400, "p3_next_done");
        check("p3_next_err", dut_last_err, 1'b0);
        drain();

        // ADC busy for 10 cycles on entry to START
        k_allow = 4'b0010; k_req = 100; k_hold = 10; k_vfix = 4;
        base = acks_model;
        r0 = dut_restarts;
        run_until(base + 1, 400, "p4_done");
        check("p4_pulses", 32'(dut_restarts - r0), NPASS);
        check("p4_restart_cyc", dut_restart_cyc, m_g + S + 1 + 10 + (NPASS - 1) * 16);
        drain();

        // Reset in the middle of WAIT for channel 2
        k_allow = 4'b0100; k_req = 100; k_vfix = 30;
        begin
            int n;
            n = 0;
            while (!(m_act && m_r >= 0 && cyc > m_r + 3) && n < 300) begin
                step();
                n++;
            end
            check("p5_in_wait", 32'(m_act && m_r >= 0), 32'd1);
        end
        base_dut = dut_acks;
        k_rst = 1;
        step();
        check("p5_no_ack", dut_acks, base_dut);
        k_allow = 4'b1111; k_keep = 0; k_vfix = 4;
        base = acks_model;
        run_until(base + 1, 400, "p5_done");
        check("p5_first_ch", ack_log[ack_log.size() - 1], 0);
        check("p5_nacks", 32'(dut_acks - base_dut), 1);
        drain();

        // Randomized traffic
        k_vfix = 0; k_cnt_mode = 0;
        for (int blk = 0; blk < 12; blk++) begin
            k_allow = 4'($urandom_range(15, 1));
            k_req = $urandom_range(60, 5);
            k_busy = $urandom_range(50, 0);
            k_noise = $urandom_range(40, 0);
            k_to = $urandom_range(3, 0);
            k_drop = $urandom_range(3, 0);
            k_keep = $urandom_range(100, 0);
            k_vmax = $urandom_range(25, 1);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(999, 0) == 0) k_rst = 1;
                step();
            end
        end
        k_busy = 0; k_noise = 0; k_to = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
